// File: rtl/map_display_pkg.sv
// Shared constants and scanner state encoding for the map display path.
// Pixels are active-low throughout: a 0 bit lights an LED.
package map_display_pkg;

  localparam int DATA_WIDTH    = 35;
  localparam int COLUNE_SIZE   = 7;
  localparam int TOTAL_COLUNES = 5;

  localparam logic PIXEL_ON = 1'b0;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_BLANK = 2'd3
  } scan_state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_tick_counter.sv
// Loadable down-counter that flags terminal count; times both the column
// drive window and the inter-column blanking window.
module scan_tick_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  output logic             o_terminal
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_terminal = (r_count == '0);

endmodule

// File: rtl/map_matrix_scanner.sv
// Column-multiplexed driver for the 5x7 LED matrix; snapshots the pixel map
// once per frame so code changes never tear the displayed image.
module map_matrix_scanner
  import map_display_pkg::*;
#(
  parameter int DATA_WIDTH    = map_display_pkg::DATA_WIDTH,
  parameter int COLUNE_SIZE   = map_display_pkg::COLUNE_SIZE,
  parameter int TOTAL_COLUNES = map_display_pkg::TOTAL_COLUNES,
  parameter int PRESCALE      = 50000,
  parameter int BLANK_CYCLES  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [DATA_WIDTH-1:0]    i_mapIn,
  output logic [TOTAL_COLUNES-1:0] o_colSel,
  output logic [COLUNE_SIZE-1:0]   o_rowOut,
  output logic                     o_frameDone
);

  localparam int CNT_W = $clog2(maxInt(PRESCALE, BLANK_CYCLES) + 1);
  localparam int COL_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;

  localparam logic [CNT_W-1:0]       DRIVE_LOAD = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]       BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [COL_W-1:0]       LAST_COL   = COL_W'(TOTAL_COLUNES - 1);
  localparam logic [COLUNE_SIZE-1:0] ROW_DARK   = {COLUNE_SIZE{~PIXEL_ON}};

  scan_state_t             r_state;
  logic [COL_W-1:0]        r_colIdx;
  logic [DATA_WIDTH-1:0]   r_frameBuf;

  logic                    w_terminal;
  logic                    w_load;
  logic [CNT_W-1:0]        w_loadValue;
  logic [COL_W-1:0]        w_nextIdx;
  logic                    w_lastCol;
  logic [COLUNE_SIZE-1:0]  w_frameRows [TOTAL_COLUNES];

  for (genvar c = 0; c < TOTAL_COLUNES; c++) begin : g_rows
    assign w_frameRows[c] = r_frameBuf[c*COLUNE_SIZE +: COLUNE_SIZE];
  end

  assign w_nextIdx = r_colIdx + COL_W'(1);
  assign w_lastCol = (r_colIdx == LAST_COL);

  // The counter is reloaded on every transition into DRIVE or BLANK.
  always_comb begin
    w_load      = 1'b0;
    w_loadValue = DRIVE_LOAD;
    case (r_state)
      ST_LOAD: w_load = 1'b1;
      ST_DRIVE: begin
        if (w_terminal) begin
          w_load = 1'b1;
          if (BLANK_CYCLES > 0) w_loadValue = BLANK_LOAD;
        end
      end
      ST_BLANK: w_load = w_terminal;
      default: ;
    endcase
  end

  scan_tick_counter #(
    .WIDTH(CNT_W)
  ) u_tickCounter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (!i_enable),
    .i_load     (w_load),
    .i_loadValue(w_loadValue),
    .o_terminal (w_terminal)
  );

  // Outputs are set together with the state they belong to, so they stay
  // registered yet aligned with r_state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_OFF;
      r_colIdx    <= '0;
      r_frameBuf  <= '1;
      o_colSel    <= '0;
      o_rowOut    <= ROW_DARK;
      o_frameDone <= 1'b0;
    end else if (!i_enable) begin
      r_state     <= ST_OFF;
      r_colIdx    <= '0;
      o_colSel    <= '0;
      o_rowOut    <= ROW_DARK;
      o_frameDone <= 1'b0;
    end else begin
      o_frameDone <= 1'b0;
      case (r_state)
        ST_OFF: begin
          r_state  <= ST_LOAD;
          o_colSel <= '0;
          o_rowOut <= ROW_DARK;
        end
        ST_LOAD: begin
          r_frameBuf <= i_mapIn;
          r_colIdx   <= '0;
          r_state    <= ST_DRIVE;
          o_colSel   <= TOTAL_COLUNES'(1);
          o_rowOut   <= i_mapIn[COLUNE_SIZE-1:0];
        end
        ST_DRIVE, ST_BLANK: begin
          if (w_terminal) begin
            if (r_state == ST_DRIVE && BLANK_CYCLES > 0) begin
              r_state  <= ST_BLANK;
              o_colSel <= '0;
              o_rowOut <= ROW_DARK;
            end else if (w_lastCol) begin
              r_state     <= ST_LOAD;
              o_frameDone <= 1'b1;
              o_colSel    <= '0;
              o_rowOut    <= ROW_DARK;
            end else begin
              r_colIdx <= w_nextIdx;
              r_state  <= ST_DRIVE;
              o_colSel <= TOTAL_COLUNES'(1) << w_nextIdx;
              o_rowOut <= w_frameRows[w_nextIdx];
            end
          end
        end
        default: begin
          r_state  <= ST_OFF;
          o_colSel <= '0;
          o_rowOut <= ROW_DARK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_matrix_scanner.sv
// Scoreboard bench for map_matrix_scanner: a PRESCALE=4/BLANK=1 build and a
// BLANK_CYCLES=0 build, checked cycle by cycle against hand-derived schedules.
module tb_map_matrix_scanner;

  logic        clk = 1'b0;
  logic        reset, enable, enable0;
  logic [34:0] mapIn, mapIn0;
  logic [4:0]  colSel, colSel0;
  logic [6:0]  rowOut, rowOut0;
  logic        frameDone, frameDone0;

  always #5 clk = ~clk;

  map_matrix_scanner #(.PRESCALE(4), .BLANK_CYCLES(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_mapIn(mapIn),
    .o_colSel(colSel), .o_rowOut(rowOut), .o_frameDone(frameDone)
  );

  map_matrix_scanner #(.PRESCALE(4), .BLANK_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable0), .i_mapIn(mapIn0),
    .o_colSel(colSel0), .o_rowOut(rowOut0), .o_frameDone(frameDone0)
  );

  typedef struct packed {
    logic       sel;
    logic [4:0] colSel;
    logic [6:0] rowOut;
    logic       done;
  } exp_t;

  exp_t  sbQ[$];
  string tagQ[$];
  int    checkCount = 0;
  int    passCount  = 0;

  logic [34:0] oneLow;
  logic [34:0] pattern;

  task automatic expectOutput(input logic sel, input logic [4:0] cs, input logic [6:0] ro,
                              input logic d, input string tag);
    exp_t e;
    e.sel = sel; e.colSel = cs; e.rowOut = ro; e.done = d;
    sbQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [34:0] m,
                               input logic en0, input logic [34:0] m0);
    reset = rst; enable = en; mapIn = m; enable0 = en0; mapIn0 = m0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [12:0] act, input logic [12:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got colSel=%b rowOut=%b frameDone=%b, expected colSel=%b rowOut=%b frameDone=%b",
                  tag, act[12:8], act[7:1], act[0], exp[12:8], exp[7:1], exp[0]);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      exp_t  e;
      string t;
      logic [12:0] act;
      e = sbQ.pop_front();
      t = tagQ.pop_front();
      act = e.sel ? {colSel0, rowOut0, frameDone0} : {colSel, rowOut, frameDone};
      checkOutput(t, act, {e.colSel, e.rowOut, e.done});
    end
  end

  // One frame starting at its LOAD cycle. abortMode 1 drops enable and
  // abortMode 2 asserts reset during cycle abortIdx, then returns.
  task automatic runFrame(input logic sel, input logic [34:0] fb, input logic [34:0] later,
                          input int changeIdx, input logic done0, input int abortIdx,
                          input int abortMode, input string tag);
    int period, frameLen, slot, col;
    logic [4:0]  cs;
    logic [6:0]  ro;
    logic [34:0] m;
    period   = sel ? 4 : 5;
    frameLen = 1 + 5 * period;
    for (int i = 0; i < frameLen; i++) begin
      cs = 5'b0;
      ro = 7'h7F;
      if (i > 0) begin
        slot = (i - 1) % period;
        col  = (i - 1) / period;
        if (slot < 4) begin
          cs = 5'b1 << col;
          ro = fb[col*7 +: 7];
        end
      end
      expectOutput(sel, cs, ro, (i == 0) ? done0 : 1'b0, tag);
      m = (i < changeIdx) ? fb : later;
      if (i == abortIdx) begin
        applyStimulus(abortMode == 2, abortMode != 1, m, 1'b0, '1);
        return;
      end
      if (sel) applyStimulus(1'b0, 1'b0, '1, 1'b1, m);
      else     applyStimulus(1'b0, 1'b1, m, 1'b0, '1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far",
             passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    oneLow  = ~35'h1;
    pattern = {7'h55, 7'h77, 7'h6B, 7'h5D, 7'h3E};

    applyStimulus(1'b1, 1'b0, '1, 1'b0, '1);
    applyStimulus(1'b1, 1'b0, '1, 1'b0, '1);
    expectOutput(1'b0, 5'b0, 7'h7F, 1'b0, "reset");
    applyStimulus(1'b0, 1'b1, oneLow, 1'b0, '1);

    runFrame(1'b0, oneLow, oneLow, 99, 1'b0, -1, 0, "singlePixel");
    runFrame(1'b0, 35'h0, 35'h0, 99, 1'b1, -1, 0, "walkAllOn");
    runFrame(1'b0, pattern, pattern, 99, 1'b1, -1, 0, "pattern");
    runFrame(1'b0, '1, 35'h0, 12, 1'b1, -1, 0, "tearHold");
    runFrame(1'b0, 35'h0, 35'h0, 99, 1'b1, -1, 0, "tearNext");
    runFrame(1'b0, pattern, pattern, 99, 1'b1, 17, 1, "enableDrop");

    for (int i = 0; i < 30; i++) begin
      expectOutput(1'b0, 5'b0, 7'h7F, 1'b0, "disabled");
      applyStimulus(1'b0, 1'b0, pattern, 1'b0, '1);
    end
    expectOutput(1'b0, 5'b0, 7'h7F, 1'b0, "reenable");
    applyStimulus(1'b0, 1'b1, pattern, 1'b0, '1);
    runFrame(1'b0, pattern, pattern, 99, 1'b0, -1, 0, "restart");

    runFrame(1'b0, pattern, pattern, 99, 1'b1, 25, 2, "resetInBlank");
    expectOutput(1'b0, 5'b0, 7'h7F, 1'b0, "afterReset");
    applyStimulus(1'b0, 1'b1, oneLow, 1'b0, '1);
    runFrame(1'b0, oneLow, oneLow, 99, 1'b0, -1, 0, "resetRestart");

    expectOutput(1'b1, 5'b0, 7'h7F, 1'b0, "noBlankOff");
    applyStimulus(1'b0, 1'b0, '1, 1'b1, pattern);
    runFrame(1'b1, pattern, pattern, 99, 1'b0, -1, 0, "noBlankFrame1");
    runFrame(1'b1, 35'h0, 35'h0, 99, 1'b1, -1, 0, "noBlankFrame2");

    @(negedge clk);
    #1;
    checkCount++;
    if (sbQ.size() == 0) passCount++;
    else $display("[TB] FAIL drain: %0d expectations left, required 0", sbQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
